// File: rtl/sram_sp_16x128_ctrl.sv
// Generic synchronous FIFO used as the read-response buffer.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: the head stays put while out_rdy is low. A push into a full FIFO is dropped unless a pop happens in the same cycle.
module fifo_sync #(
    parameter int W     = 128,
    parameter int LOG2D = 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [W-1:0]     in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [W-1:0]     out_dat,
    output logic [LOG2D:0]   cnt
);
    localparam int DEPTH = 2**LOG2D;

    logic [W-1:0]     mem [DEPTH];
    logic [LOG2D-1:0] wr_ptr;
    logic [LOG2D-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    assign full    = (cnt == (LOG2D+1)'(DEPTH));
    assign out_vld = (cnt != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld & out_rdy;
    assign push    = in_vld & (~full | pop);

    // Pointer, occupancy and storage update; reset also clears storage so the head reads zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (LOG2D+1)'(push) - (LOG2D+1)'(pop);
        end
    end
endmodule

// Request-side controller for the 16x128 single-port SRAM: clears the array after reset, then maps requests onto ME/WE/ADR/D.
// Latency: a read accepted in cycle N has its response valid from cycle N+2. Writes produce no response.
// Backpressure: req_ready drops when the in-flight read plus the buffered responses, minus any pop this cycle, would reach 2.
module sram_sp_16x128_ctrl #(
    parameter int              AW       = 4,
    parameter int              DW       = 128,
    parameter bit              INIT_EN  = 1'b1,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic          mem_me,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] init_cnt_nxt;
    logic          inflight;
    logic [1:0]    occ;
    logic          pop;
    logic [2:0]    pend;

    assign pop  = rsp_valid & rsp_ready;
    // occ is never zero while pop is set, so this cannot underflow.
    assign pend = {2'b00, inflight} + {1'b0, occ} - {2'b00, pop};

    // State and clear-address register; reset restarts the clear from address 0.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next state plus the SRAM and handshake outputs. Reset forces the SRAM and handshake outputs inactive.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        mem_me       = 1'b0;
        mem_we       = 1'b0;
        mem_adr      = req_adr;
        mem_d        = req_wdata;
        case (state)
            ST_INIT: begin
                mem_me       = 1'b1;
                mem_we       = 1'b1;
                mem_adr      = init_cnt;
                mem_d        = INIT_VAL;
                init_cnt_nxt = init_cnt + 1'b1;
                if (&init_cnt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                req_ready = (pend < 3'd2);
                mem_me    = req_valid & req_ready;
                mem_we    = req_valid & req_ready & req_we;
            end
        endcase
        if (reset) begin
            req_ready = 1'b0;
            init_done = 1'b0;
            mem_me    = 1'b0;
            mem_we    = 1'b0;
        end
    end

    // Marks that mem_q carries read data this cycle: the SRAM returns Q one cycle after a read ME.
    always_ff @(posedge CLK) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= req_valid & req_ready & ~req_we;
        end
    end

    fifo_sync #(
        .W     (DW),
        .LOG2D (1)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .in_vld  (inflight),
        .in_dat  (mem_q),
        .out_vld (rsp_valid),
        .out_rdy (rsp_ready),
        .out_dat (rsp_rdata),
        .cnt     (occ)
    );
endmodule

// File: tb/tb_sram_sp_16x128_ctrl.sv
// Directed bench for sram_sp_16x128_ctrl, with a behavioural single-port SRAM attached.
// Latency: expects read responses two cycles after accept.
// Backpressure: exercises rsp_ready low with the buffer full, then releases it.
module tb_sram_sp_16x128_ctrl;
    logic         CLK = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [3:0]   req_adr;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;
    logic         init_done;
    logic         mem_me;
    logic         mem_we;
    logic [3:0]   mem_adr;
    logic [127:0] mem_d;
    logic [127:0] mem_q = '0;

    logic         req_ready0;
    logic         rsp_valid0;
    logic [127:0] rsp_rdata0;
    logic         init_done0;
    logic         mem_me0;
    logic         mem_we0;
    logic [3:0]   mem_adr0;
    logic [127:0] mem_d0;

    logic [127:0] sram [16];
    int           checks = 0;
    int           errors = 0;

    always #5 CLK = ~CLK;

    sram_sp_16x128_ctrl u_dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .mem_me(mem_me), .mem_we(mem_we), .mem_adr(mem_adr), .mem_d(mem_d), .mem_q(mem_q)
    );

    sram_sp_16x128_ctrl #(.INIT_EN(1'b0)) u_dut0 (
        .CLK(CLK), .reset(reset),
        .req_valid(1'b0), .req_ready(req_ready0), .req_we(1'b0),
        .req_adr(4'h0), .req_wdata(128'h0),
        .rsp_valid(rsp_valid0), .rsp_ready(1'b0), .rsp_rdata(rsp_rdata0),
        .init_done(init_done0),
        .mem_me(mem_me0), .mem_we(mem_we0), .mem_adr(mem_adr0), .mem_d(mem_d0), .mem_q(128'h0)
    );

    // Single-port SRAM: write or read registered on ME, Q held otherwise.
    always @(posedge CLK) begin
        if (mem_me) begin
            if (mem_we) sram[mem_adr] <= mem_d;
            else        mem_q <= sram[mem_adr];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i * 17) ^ 8'h5A;
        return {16{b}};
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Clear sequence: 16 writes of zero to addresses 0..15, then init_done and req_ready high.
    task automatic chk_init(input bit first);
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            check("init_mewe", {126'h0, mem_me, mem_we}, 128'h3);
            check("init_adr", 128'(mem_adr), 128'(k));
            check("init_d", mem_d, 128'h0);
            check("init_done_lo", 128'(init_done), 128'h0);
            check("init_rdy_lo", 128'(req_ready), 128'h0);
            check("init_rspv", 128'(rsp_valid), 128'h0);
            if (k == 0) begin
                check("init_rdata", rsp_rdata, 128'h0);
                if (first) begin
                    check("noinit_rdy", 128'(req_ready0), 128'h1);
                    check("noinit_done", 128'(init_done0), 128'h1);
                end
            end
            cyc();
        end
        @(negedge CLK);
        check("init_done_hi", 128'(init_done), 128'h1);
        check("run_rdy", 128'(req_ready), 128'h1);
        cyc();
    endtask

    task automatic rd_burst(input int n, input bit zero);
        rsp_ready = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            req_valid = (i < n);
            req_we    = 1'b0;
            req_adr   = 4'(i);
            @(negedge CLK);
            if (i < n) check("rd_ready", 128'(req_ready), 128'h1);
            if (i >= 2) begin
                check("rd_vld", 128'(rsp_valid), 128'h1);
                check("rd_dat", rsp_rdata, zero ? 128'h0 : pat(i - 2));
            end else begin
                check("rd_lat", 128'(rsp_valid), 128'h0);
            end
            cyc();
        end
        req_valid = 1'b0;
        @(negedge CLK);
        check("rd_tail", 128'(rsp_valid), 128'h0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = {16{8'hFF}};
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0; rsp_ready = 1'b0;
        cyc();
        @(negedge CLK);
        check("rst_rdy", 128'(req_ready), 128'h0);
        check("rst_mewe", {126'h0, mem_me, mem_we}, 128'h0);
        check("rst_rspv", 128'(rsp_valid), 128'h0);
        check("rst_done", 128'(init_done), 128'h0);
        check("rst_rdy0", 128'(req_ready0), 128'h0);
        check("rst_done0", 128'(init_done0), 128'h0);
        cyc();
        reset = 1'b0;
        chk_init(1'b1);

        // Cleared array reads back zero.
        rd_burst(16, 1'b1);

        // Distinct pattern into every word, back-to-back writes.
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_adr = 4'(i); req_wdata = pat(i);
            @(negedge CLK);
            check("wr_ready", 128'(req_ready), 128'h1);
            check("wr_we", 128'(mem_we), 128'h1);
            check("wr_adr", 128'(mem_adr), 128'(i));
            check("wr_d", mem_d, pat(i));
            cyc();
        end
        req_valid = 1'b0; req_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("wr_norsp", 128'(rsp_valid), 128'h0);
            cyc();
        end
        rd_burst(16, 1'b0);

        // Write then immediate read of the same address.
        req_valid = 1'b1; req_we = 1'b1; req_adr = 4'd3; req_wdata = {16{8'hA5}};
        @(negedge CLK);
        check("raw_wr", {126'h0, req_ready, mem_we}, 128'h3);
        cyc();
        req_we = 1'b0;
        @(negedge CLK);
        check("raw_rd", {126'h0, mem_me, mem_we}, 128'h2);
        cyc();
        req_valid = 1'b0;
        @(negedge CLK);
        check("raw_lat", 128'(rsp_valid), 128'h0);
        cyc();
        @(negedge CLK);
        check("raw_vld", 128'(rsp_valid), 128'h1);
        check("raw_dat", rsp_rdata, {16{8'hA5}});
        cyc();
        @(negedge CLK);
        check("raw_pop", 128'(rsp_valid), 128'h0);
        cyc();

        // Backpressure: three reads with rsp_ready low.
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_adr = 4'd5;
        @(negedge CLK); check("bp_rdy0", 128'(req_ready), 128'h1); cyc();
        req_adr = 4'd6;
        @(negedge CLK); check("bp_rdy1", 128'(req_ready), 128'h1); cyc();
        req_adr = 4'd7;
        @(negedge CLK);
        check("bp_full", 128'(req_ready), 128'h0);
        check("bp_vld", 128'(rsp_valid), 128'h1);
        check("bp_dat2", rsp_rdata, pat(5));
        cyc();
        @(negedge CLK);
        check("bp_full3", 128'(req_ready), 128'h0);
        check("bp_nome", 128'(mem_me), 128'h0);
        check("bp_dat3", rsp_rdata, pat(5));
        cyc();
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_rel_rdy", 128'(req_ready), 128'h1);
        check("bp_rel_me", {123'h0, mem_me, mem_adr}, {123'h0, 1'b1, 4'd7});
        check("bp_rel_dat", rsp_rdata, pat(5));
        cyc();
        req_valid = 1'b0;
        @(negedge CLK);
        check("bp_vld6", 128'(rsp_valid), 128'h1);
        check("bp_dat6", rsp_rdata, pat(6));
        cyc();
        @(negedge CLK);
        check("bp_vld7", 128'(rsp_valid), 128'h1);
        check("bp_dat7", rsp_rdata, pat(7));
        cyc();
        @(negedge CLK);
        check("bp_empty", 128'(rsp_valid), 128'h0);
        cyc();

        // Reset with one response buffered and one read in flight.
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_adr = 4'd0;
        @(negedge CLK); check("mr_rdy0", 128'(req_ready), 128'h1); cyc();
        req_adr = 4'd1;
        @(negedge CLK); check("mr_rdy1", 128'(req_ready), 128'h1); cyc();
        req_valid = 1'b0; reset = 1'b1;
        @(negedge CLK);
        check("mr_vld", 128'(rsp_valid), 128'h1);
        check("mr_gate", {126'h0, mem_me, req_ready}, 128'h0);
        cyc();
        reset = 1'b0;
        chk_init(1'b0);
        rd_burst(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
